// File: rtl/mix_columns_seq.sv
// mix_columns_seq: sequential forward AES MixColumns with a valid/ready handshake
// on both sides; transforms COLS_PER_CYCLE columns of the captured state per clock.
`default_nettype none

module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_state,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_state,
    output logic         busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [1:0] CNT_STEP = COLS_PER_CYCLE[1:0];

    logic [1:0]   state;
    logic [1:0]   cnt;
    logic [127:0] work;
    logic [127:0] next_work;
    logic         last_step;
    int           col_idx;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        r0 = xtime(a0) ^ (xtime(a1) ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ xtime(a1) ^ (xtime(a2) ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ xtime(a2) ^ (xtime(a3) ^ a3);
        r3 = (xtime(a0) ^ a0) ^ a1 ^ a2 ^ xtime(a3);
        return {r0, r1, r2, r3};
    endfunction

    // Column c lives at bits [127-32c -: 32]; untouched columns keep their input value.
    always_comb begin
        next_work = work;
        col_idx   = 0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
            col_idx = int'(cnt) + k;
            if (col_idx < 4) begin
                next_work[(3 - col_idx) * 32 +: 32] = mix_col(work[(3 - col_idx) * 32 +: 32]);
            end
        end
    end

    assign last_step = (int'(cnt) + COLS_PER_CYCLE) >= 4;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 2'd0;
            work  <= 128'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work  <= in_state;
                        cnt   <= 2'd0;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    work <= next_work;
                    if (last_step) begin
                        cnt   <= 2'd0;
                        state <= DONE;
                    end else begin
                        cnt <= cnt + CNT_STEP;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= 2'd0;
                end
            endcase
        end
    end

    assign in_ready  = (state == IDLE);
    assign busy      = (state == BUSY);
    assign out_valid = (state == DONE);
    assign out_state = (state == DONE) ? work : 128'd0;

endmodule

`default_nettype wire

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: drives three instances (1, 2 and 4 columns per cycle) with shared
// stimulus and checks them against a GF(2^8) matrix model plus hand-computed vectors.
`default_nettype none

module tb_mix_columns_seq;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         out_ready = 1'b0;
    logic [127:0] in_state = 128'd0;
    logic [2:0]   in_ready;
    logic [2:0]   out_valid;
    logic [2:0]   busy;
    logic [127:0] out_st [3];

    int compared = 0;
    int mismatched = 0;
    int outs [3] = '{0, 0, 0};
    logic [127:0] exp_q [3][$];

    always #5 clk = ~clk;

    for (genvar d = 0; d < 3; d++) begin : g_dut
        mix_columns_seq #(.COLS_PER_CYCLE(1 << d)) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid),
            .in_ready  (in_ready[d]),
            .in_state  (in_state),
            .out_valid (out_valid[d]),
            .out_ready (out_ready),
            .out_state (out_st[d]),
            .busy      (busy[d])
        );
    end

    // Generic GF(2^8) multiply (shift-and-add modulo x^8+x^4+x^3+x+1).
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'd0;
        logic       hi;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ a;
            hi = a[7];
            a  = {a[6:0], 1'b0};
            if (hi) a = a ^ 8'h1b;
        end
        return p;
    endfunction

    // Circulant matrix rows: coefficient for input byte k in output row r is coef[(k-r) mod 4].
    function automatic logic [127:0] ref_mix(input logic [127:0] s);
        logic [7:0]   coef [4] = '{8'd2, 8'd3, 8'd1, 8'd1};
        logic [127:0] res = 128'd0;
        logic [7:0]   acc;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                acc = 8'd0;
                for (int k = 0; k < 4; k++)
                    acc = acc ^ gmul(s[127 - 32*c - 8*k -: 8], coef[(k - r + 4) % 4]);
                res[127 - 32*c - 8*r -: 8] = acc;
            end
        end
        return res;
    endfunction

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            for (int d = 0; d < 3; d++) exp_q[d].delete();
        end else begin
            for (int d = 0; d < 3; d++) begin
                if (out_valid[d]) begin
                    if (exp_q[d].size() == 0) begin
                        compared++;
                        mismatched++;
                        $display("FAIL unexpected_output c%0d: got %h expected no output", 1 << d, out_st[d]);
                    end else begin
                        chk($sformatf("model_c%0d", 1 << d), out_st[d], exp_q[d][0]);
                        if (out_ready) begin
                            void'(exp_q[d].pop_front());
                            outs[d]++;
                        end
                    end
                end
                if (in_valid && in_ready[d]) exp_q[d].push_back(ref_mix(in_state));
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        while (in_ready !== 3'b111 && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n == 50) begin
            compared++;
            mismatched++;
            $display("FAIL idle_timeout: got in_ready %b expected 111", in_ready);
        end
    endtask

    task automatic send(input logic [127:0] v, input logic [127:0] exp, input int hold);
        int lat [3];
        wait_idle();
        in_state  = v;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("busy_after_accept", {125'd0, busy}, 128'd7);
        chk("in_ready_while_busy", {125'd0, in_ready}, 128'd0);
        lat = '{0, 0, 0};
        for (int cyc = 1; cyc <= 6; cyc++) begin
            @(posedge clk); #1;
            for (int d = 0; d < 3; d++)
                if (out_valid[d] && lat[d] == 0) lat[d] = cyc;
        end
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("latency_c%0d", 1 << d), 128'(lat[d]), 128'(4 >> d));
            chk($sformatf("result_c%0d", 1 << d), out_st[d], exp);
        end
        if (hold > 0) begin
            in_valid = 1'b1;
            in_state = ~v;
            repeat (hold) begin
                @(posedge clk); #1;
                chk("hold_stable", out_st[0], exp);
                chk("hold_in_ready", {125'd0, in_ready}, 128'd0);
                chk("hold_out_valid", {125'd0, out_valid}, 128'd7);
            end
            in_valid = 1'b0;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("out_valid_after_accept", {125'd0, out_valid}, 128'd0);
        chk("in_ready_after_accept", {125'd0, in_ready}, 128'd7);
    endtask

    localparam logic [127:0] T1_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
    localparam logic [127:0] T1_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
    localparam logic [127:0] FB_IN  = 128'hd4bf5d30_e0b452ae_b84111f1_1e2798e5;
    localparam logic [127:0] FB_OUT = 128'h046681e5_e0cb199a_48f8d37a_2806264c;
    localparam logic [127:0] RD_IN  = 128'hd4d4d4d5_2d26314c_00000000_ffffffff;
    localparam logic [127:0] RD_OUT = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff;

    initial begin
        int base0;
        int n;
        chk("model_pin_t1", ref_mix(T1_IN), T1_OUT);
        chk("model_pin_fips", ref_mix(FB_IN), FB_OUT);
        chk("model_pin_reduce", ref_mix(RD_IN), RD_OUT);

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            chk("reset_in_ready", {127'd0, in_ready[d]}, 128'd1);
            chk("reset_out_valid", {127'd0, out_valid[d]}, 128'd0);
            chk("reset_busy", {127'd0, busy[d]}, 128'd0);
            chk("reset_out_state", out_st[d], 128'd0);
        end

        send(T1_IN, T1_OUT, 0);
        send(FB_IN, FB_OUT, 0);
        send(RD_IN, RD_OUT, 0);
        send(FB_IN, FB_OUT, 10);

        // Abort after two of four columns on the single-column instance.
        wait_idle();
        in_state  = RD_IN;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("busy_before_reset", {127'd0, busy[0]}, 128'd1);
        rst = 1'b1;
        #1;
        chk("reset_mid_out_valid", {125'd0, out_valid}, 128'd0);
        chk("reset_mid_out_state", out_st[0], 128'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_reset_in_ready", {125'd0, in_ready}, 128'd7);
        chk("post_reset_out_state", out_st[0], 128'd0);
        send(T1_IN, T1_OUT, 0);

        // Streaming with continuous in_valid and random back-pressure.
        base0    = outs[0];
        in_valid = 1'b1;
        n = 0;
        while (outs[0] < base0 + 5 && n < 300) begin
            in_state  = {$urandom, $urandom, $urandom, $urandom};
            out_ready = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            n++;
        end
        if (n == 300) begin
            compared++;
            mismatched++;
            $display("FAIL stream_timeout: got %0d outputs expected 5", outs[0] - base0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++)
            chk($sformatf("drain_empty_c%0d", 1 << d), 128'(exp_q[d].size()), 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire
